sram_read_arbiter: RTL and testbench
====================================

Name: sram_read_arbiter

Overview:
- Shares the single-port sequence SRAM between the query parser and the target parser.
- Each parser presents a level request with a word address. The arbiter issues at most one SRAM read per cycle, tags each read, and routes the returned word to its owner with a one-cycle valid pulse.
- Each requester may have at most one read outstanding, because a parser only advances its address after valid.
- Round-robin priority stops either parser from starving the other.

Parameters:
- ADDR_W, 10, SRAM word address width (matches the SRAM address width macro).
- DATA_W, 48, SRAM word width (matches the SRAM word width macro).
- READ_LAT, 2, SRAM cycles from read enable to data on sram_data_i (range 1..4).
- Q_BASE, 0, SRAM base address added to the query address.
- T_BASE, 512, SRAM base address added to the target address.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous abort: drop in-flight reads, clear outstanding state
- q_request_i  in  1  query parser wants a word
- q_addr_i  in  ADDR_W  query word address (relative to Q_BASE)
- q_data_o  out  DATA_W  returned query word
- q_valid_o  out  1  q_data_o valid (1-cycle pulse)
- t_request_i  in  1  target parser wants a word
- t_addr_i  in  ADDR_W  target word address (relative to T_BASE)
- t_data_o  out  DATA_W  returned target word
- t_valid_o  out  1  t_data_o valid (1-cycle pulse)
- sram_re_o  out  1  SRAM read enable
- sram_addr_o  out  ADDR_W  SRAM read address
- sram_data_i  in  DATA_W  SRAM read data, READ_LAT cycles after sram_re_o
- busy_o  out  1  any read outstanding

Behaviour:
- Reset: every output register is 0. q_out and t_out are 0. last_grant is T, so Q wins the first contest. The tag pipeline is all invalid.
- Reset mid-operation: in-flight reads are discarded and no valid pulse appears after rst_n deasserts.
- Eligibility in cycle C: X is eligible if x_request_i=1, x_out=0 and flush_i=0.
- Arbitration:
  - If only one requester is eligible, it is granted.
  - If both are eligible, grant the one not equal to last_grant, then update last_grant.
  - A grant registers sram_re_o=1 and sram_addr_o=(BASE_X + x_addr_i) mod 2^ADDR_W at edge C→C+1.
  - sram_re_o is 0 in every cycle with no grant, and sram_addr_o holds its previous value.
- Tag pipeline:
  - The shift register depth is READ_LAT+1, entries {valid, owner}.
  - The entry enters alongside sram_re_o.
  - At the cycle where sram_data_i carries the word (C+1+READ_LAT), the data is registered into the owner's data_o.
  - valid_o pulses in cycle C+2+READ_LAT.
  - Request-to-valid latency is READ_LAT+2 cycles (4 at the default).
- Non-owner data outputs hold their previous value; valid pulses only for the owner. q_valid_o and t_valid_o can never both be 1 in the same cycle.
- Outstanding flags:
  - x_out is set on grant.
  - x_out is cleared at the edge ending the cycle in which x_valid_o=1.
  - The parser's updated address can therefore be granted in the cycle right after valid.
  - The peak per-requester rate is one word every READ_LAT+3 cycles. Both requesters interleave.
- Simultaneous grant and return for different owners are independent. A grant for the same owner cannot occur while its flag is set.
- A request dropped while outstanding still receives its valid pulse; the data is not cancelled.
- flush_i=1:
  - No grant in that cycle.
  - All tag valids clear at the edge, so no valid pulses for in-flight reads.
  - Both outstanding flags clear; last_grant is unchanged.
  - sram_re_o is 0 next cycle.
  - Data arriving from the SRAM after a flush is ignored.
- busy_o is registered and equals (q_out | t_out) of the next state. It is 0 the cycle after flush.
- Address arithmetic is an ADDR_W-bit unsigned add, and carry is discarded: T_BASE=512, t_addr_i=600 gives sram_addr_o=88.

Test Plan:
- Reset, then q_request_i=1 with q_addr_i=5 held at cycle 0. Expect sram_re_o=1 and sram_addr_o=5 at cycle 1, and q_valid_o=1 with q_data_o equal to the SRAM word at 5 at cycle 4. There is no second sram_re_o before cycle 5; incrementing q_addr_i to 6 at cycle 5 gives sram_addr_o=6 at cycle 6.
- Both requesters held high with q_addr=0 and t_addr=0 from reset. Expect grants in the order Q, T, Q, T, …, with sram_addr_o sequence 0, 512, 1, 513. Expect no cycle where q_valid_o and t_valid_o are both 1.
- t_request_i held high with t_addr_i=600. Expect sram_addr_o=88 (wrap).
- Assert flush_i for one cycle two cycles after a Q grant. Expect no q_valid_o for that read, busy_o=0 the next cycle, and a new Q request granted the cycle after flush deasserts.
- Pull rst_n low while two reads are in flight, then release it. Expect all outputs 0, no valid pulses, and Q winning the first contest when both request.
- Drop q_request_i one cycle after its grant. Expect q_valid_o to still pulse once at grant+3, and no further Q reads.

Source files
------------

// File: rtl/sram_read_arbiter.sv
// Two-way round-robin read arbiter in front of the shared single-port sequence SRAM.
// Each read is tagged with its owner and the returned word is steered back with a 1-cycle valid.
module sram_read_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 48,
  parameter int READ_LAT = 2,
  parameter int Q_BASE   = 0,
  parameter int T_BASE   = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              q_request_i,
  input  logic [ADDR_W-1:0] q_addr_i,
  output logic [DATA_W-1:0] q_data_o,
  output logic              q_valid_o,
  input  logic              t_request_i,
  input  logic [ADDR_W-1:0] t_addr_i,
  output logic [DATA_W-1:0] t_data_o,
  output logic              t_valid_o,
  output logic              sram_re_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic              busy_o
);

  localparam logic              OWN_Q     = 1'b0;
  localparam logic              OWN_T     = 1'b1;
  localparam int                TAG_DEPTH = READ_LAT + 1;
  localparam logic [ADDR_W-1:0] Q_BASE_A  = Q_BASE[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] T_BASE_A  = T_BASE[ADDR_W-1:0];

  logic              r_q_out;
  logic              r_t_out;
  logic              r_last_grant;
  logic              r_sram_re;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_q_data;
  logic [DATA_W-1:0] r_t_data;
  logic              r_q_valid;
  logic              r_t_valid;
  logic              r_busy;
  logic              r_tag_valid [TAG_DEPTH];
  logic              r_tag_owner [TAG_DEPTH];

  logic              w_q_elig;
  logic              w_t_elig;
  logic              w_contest;
  logic              w_grant_q;
  logic              w_grant_t;
  logic              w_grant;
  logic [ADDR_W-1:0] w_q_addr;
  logic [ADDR_W-1:0] w_t_addr;
  logic [ADDR_W-1:0] w_grant_addr;
  logic              w_ret_valid;
  logic              w_ret_q;
  logic              w_ret_t;
  logic              w_q_out_next;
  logic              w_t_out_next;

  // A requester with a read still in flight sits out until its valid has been seen.
  assign w_q_elig  = q_request_i & ~r_q_out & ~flush_i;
  assign w_t_elig  = t_request_i & ~r_t_out & ~flush_i;
  assign w_contest = w_q_elig & w_t_elig;

  assign w_grant_q = w_q_elig & (~w_t_elig | (r_last_grant == OWN_T));
  assign w_grant_t = w_t_elig & (~w_q_elig | (r_last_grant == OWN_Q));
  assign w_grant   = w_grant_q | w_grant_t;

  // Base offsets wrap modulo 2^ADDR_W; the carry is intentionally dropped.
  assign w_q_addr     = q_addr_i + Q_BASE_A;
  assign w_t_addr     = t_addr_i + T_BASE_A;
  assign w_grant_addr = w_grant_t ? w_t_addr : w_q_addr;

  assign w_ret_valid = r_tag_valid[READ_LAT] & ~flush_i;
  assign w_ret_q     = w_ret_valid & (r_tag_owner[READ_LAT] == OWN_Q);
  assign w_ret_t     = w_ret_valid & (r_tag_owner[READ_LAT] == OWN_T);

  always_comb begin
    w_q_out_next = r_q_out;
    if (flush_i) begin
      w_q_out_next = 1'b0;
    end else if (w_grant_q) begin
      w_q_out_next = 1'b1;
    end else if (r_q_valid) begin
      w_q_out_next = 1'b0;
    end
  end

  always_comb begin
    w_t_out_next = r_t_out;
    if (flush_i) begin
      w_t_out_next = 1'b0;
    end else if (w_grant_t) begin
      w_t_out_next = 1'b1;
    end else if (r_t_valid) begin
      w_t_out_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_out      <= 1'b0;
      r_t_out      <= 1'b0;
      r_busy       <= 1'b0;
      r_last_grant <= OWN_T;
    end else begin
      r_q_out <= w_q_out_next;
      r_t_out <= w_t_out_next;
      r_busy  <= w_q_out_next | w_t_out_next;
      if (w_contest) begin
        r_last_grant <= w_grant_t;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sram_re   <= 1'b0;
      r_sram_addr <= '0;
    end else begin
      r_sram_re <= w_grant;
      if (w_grant) begin
        r_sram_addr <= w_grant_addr;
      end
    end
  end

  // Tag stage 0 lines up with sram_re_o; the last stage lines up with sram_data_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_valid[0] <= 1'b0;
      r_tag_owner[0] <= OWN_Q;
    end else begin
      r_tag_valid[0] <= w_grant;
      r_tag_owner[0] <= w_grant_t;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < TAG_DEPTH; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag_valid[gi] <= 1'b0;
          r_tag_owner[gi] <= OWN_Q;
        end else begin
          r_tag_valid[gi] <= r_tag_valid[gi-1] & ~flush_i;
          r_tag_owner[gi] <= r_tag_owner[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_data  <= '0;
      r_t_data  <= '0;
      r_q_valid <= 1'b0;
      r_t_valid <= 1'b0;
    end else begin
      r_q_valid <= w_ret_q;
      r_t_valid <= w_ret_t;
      if (w_ret_q) begin
        r_q_data <= sram_data_i;
      end
      if (w_ret_t) begin
        r_t_data <= sram_data_i;
      end
    end
  end

  assign q_data_o    = r_q_data;
  assign q_valid_o   = r_q_valid;
  assign t_data_o    = r_t_data;
  assign t_valid_o   = r_t_valid;
  assign sram_re_o   = r_sram_re;
  assign sram_addr_o = r_sram_addr;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter with a READ_LAT=2 SRAM model whose words encode their address.
module tb_sram_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i;
  logic        q_request_i;
  logic [9:0]  q_addr_i;
  logic [47:0] q_data_o;
  logic        q_valid_o;
  logic        t_request_i;
  logic [9:0]  t_addr_i;
  logic [47:0] t_data_o;
  logic        t_valid_o;
  logic        sram_re_o;
  logic [9:0]  sram_addr_o;
  logic [47:0] sram_data_i;
  logic        busy_o;

  int n_vec  = 0;
  int n_miss = 0;

  sram_read_arbiter #(
    .ADDR_W(10), .DATA_W(48), .READ_LAT(2), .Q_BASE(0), .T_BASE(512)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .q_request_i(q_request_i), .q_addr_i(q_addr_i), .q_data_o(q_data_o), .q_valid_o(q_valid_o),
    .t_request_i(t_request_i), .t_addr_i(t_addr_i), .t_data_o(t_data_o), .t_valid_o(t_valid_o),
    .sram_re_o(sram_re_o), .sram_addr_o(sram_addr_o), .sram_data_i(sram_data_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] word(input logic [9:0] a);
    return {6'h2A, a, 6'h15, a, 6'h33, a};
  endfunction

  // SRAM model: data appears two cycles after the cycle sram_re_o is high.
  logic       pv [2] = '{1'b0, 1'b0};
  logic [9:0] pa [2] = '{10'd0, 10'd0};
  always @(posedge clk) begin
    pv[0] <= sram_re_o;
    pa[0] <= sram_addr_o;
    pv[1] <= pv[0];
    pa[1] <= pa[0];
  end
  assign sram_data_i = pv[1] ? word(pa[1]) : 48'hBAD0BAD0BAD0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("  ok %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_re"},    64'(sram_re_o),   64'(0));
    chk({tag, "_addr"},  64'(sram_addr_o), 64'(0));
    chk({tag, "_qv"},    64'(q_valid_o),   64'(0));
    chk({tag, "_tv"},    64'(t_valid_o),   64'(0));
    chk({tag, "_qdata"}, 64'(q_data_o),    64'(0));
    chk({tag, "_tdata"}, 64'(t_data_o),    64'(0));
    chk({tag, "_busy"},  64'(busy_o),      64'(0));
  endtask

  // Leaves the bench at cycle 0 of a fresh run, reset just released.
  task automatic do_reset();
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    q_request_i = 1'b0;
    t_request_i = 1'b0;
    q_addr_i    = 10'd0;
    t_addr_i    = 10'd0;
    tick();
    tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
  endtask

  logic [9:0] re_addrs [$];
  logic [9:0] exp_rr [4] = '{10'd0, 10'd512, 10'd1, 10'd513};
  int re_cnt;
  int qv_cnt;

  initial begin
    // Single Q read: latency and back-to-back spacing
    do_reset();
    q_request_i = 1'b1;
    q_addr_i    = 10'd5;
    tick();
    chk("s1_c1_re",   64'(sram_re_o),   64'(1));
    chk("s1_c1_addr", 64'(sram_addr_o), 64'(5));
    chk("s1_c1_busy", 64'(busy_o),      64'(1));
    tick();
    chk("s1_c2_re", 64'(sram_re_o), 64'(0));
    tick();
    chk("s1_c3_re", 64'(sram_re_o), 64'(0));
    chk("s1_c3_qv", 64'(q_valid_o), 64'(0));
    tick();
    chk("s1_c4_qv",    64'(q_valid_o), 64'(1));
    chk("s1_c4_qdata", 64'(q_data_o),  64'(word(10'd5)));
    chk("s1_c4_re",    64'(sram_re_o), 64'(0));
    chk("s1_c4_tv",    64'(t_valid_o), 64'(0));
    tick();
    chk("s1_c5_qv",   64'(q_valid_o), 64'(0));
    chk("s1_c5_re",   64'(sram_re_o), 64'(0));
    chk("s1_c5_busy", 64'(busy_o),    64'(0));
    q_addr_i = 10'd6;
    tick();
    chk("s1_c6_re",   64'(sram_re_o),   64'(1));
    chk("s1_c6_addr", 64'(sram_addr_o), 64'(6));
    q_request_i = 1'b0;
    repeat (3) tick();
    chk("s1_c9_qv",    64'(q_valid_o), 64'(1));
    chk("s1_c9_qdata", 64'(q_data_o),  64'(word(10'd6)));

    // Both parsers streaming: round-robin interleave
    do_reset();
    q_request_i = 1'b1;
    t_request_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("rr_excl", 64'(q_valid_o & t_valid_o), 64'(0));
      if (sram_re_o) re_addrs.push_back(sram_addr_o);
      if (q_valid_o) begin
        chk("rr_qdata", 64'(q_data_o), 64'(word(q_addr_i)));
        q_addr_i = q_addr_i + 10'd1;
      end
      if (t_valid_o) begin
        chk("rr_tdata", 64'(t_data_o), 64'(word(10'd512 + t_addr_i)));
        t_addr_i = t_addr_i + 10'd1;
      end
    end
    q_request_i = 1'b0;
    t_request_i = 1'b0;
    chk("rr_reads", 64'(re_addrs.size()), 64'(6));
    for (int i = 0; i < 4 && i < re_addrs.size(); i++) begin
      chk($sformatf("rr_addr%0d", i), 64'(re_addrs[i]), 64'(exp_rr[i]));
    end
    repeat (6) tick();

    // Target address wrap, request dropped after grant
    do_reset();
    t_request_i = 1'b1;
    t_addr_i    = 10'd600;
    tick();
    chk("wrap_re",   64'(sram_re_o),   64'(1));
    chk("wrap_addr", 64'(sram_addr_o), 64'(88));
    t_request_i = 1'b0;
    repeat (3) tick();
    chk("wrap_tv",    64'(t_valid_o), 64'(1));
    chk("wrap_tdata", 64'(t_data_o),  64'(word(10'd88)));
    chk("wrap_qv",    64'(q_valid_o), 64'(0));

    // Flush two cycles after a Q grant
    do_reset();
    q_request_i = 1'b1;
    q_addr_i    = 10'd20;
    tick();
    chk("fl_c1_re",   64'(sram_re_o),   64'(1));
    chk("fl_c1_addr", 64'(sram_addr_o), 64'(20));
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_c4_qv",   64'(q_valid_o), 64'(0));
    chk("fl_c4_busy", 64'(busy_o),    64'(0));
    chk("fl_c4_re",   64'(sram_re_o), 64'(0));
    q_addr_i = 10'd21;
    tick();
    chk("fl_c5_re",   64'(sram_re_o),   64'(1));
    chk("fl_c5_addr", 64'(sram_addr_o), 64'(21));
    q_request_i = 1'b0;
    tick();
    tick();
    chk("fl_c7_qv", 64'(q_valid_o), 64'(0));
    tick();
    chk("fl_c8_qv",    64'(q_valid_o), 64'(1));
    chk("fl_c8_qdata", 64'(q_data_o),  64'(word(10'd21)));

    // Reset asserted with two reads in flight
    do_reset();
    q_request_i = 1'b1;
    t_request_i = 1'b1;
    q_addr_i    = 10'd3;
    t_addr_i    = 10'd7;
    tick();
    chk("mr_c1_addr", 64'(sram_addr_o), 64'(3));
    tick();
    chk("mr_c2_addr", 64'(sram_addr_o), 64'(519));
    rst_n = 1'b0;
    #1;
    chk_all_zero("mr_async");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_c5_re",   64'(sram_re_o),   64'(1));
    chk("mr_c5_addr", 64'(sram_addr_o), 64'(3));
    chk("mr_c5_qv",   64'(q_valid_o),   64'(0));
    chk("mr_c5_tv",   64'(t_valid_o),   64'(0));
    tick();
    chk("mr_c6_addr", 64'(sram_addr_o), 64'(519));
    chk("mr_c6_qv",   64'(q_valid_o),   64'(0));
    chk("mr_c6_tv",   64'(t_valid_o),   64'(0));
    q_request_i = 1'b0;
    t_request_i = 1'b0;
    repeat (6) tick();

    // Q request dropped one cycle after its grant
    do_reset();
    q_request_i = 1'b1;
    q_addr_i    = 10'd9;
    tick();
    chk("dr_c1_re", 64'(sram_re_o), 64'(1));
    tick();
    q_request_i = 1'b0;
    re_cnt = 0;
    qv_cnt = 0;
    for (int c = 2; c <= 10; c++) begin
      if (c > 2) tick();
      if (sram_re_o) re_cnt++;
      if (q_valid_o) begin
        qv_cnt++;
        chk("dr_vcycle", 64'(c), 64'(4));
        chk("dr_qdata",  64'(q_data_o), 64'(word(10'd9)));
      end
    end
    chk("dr_reads",  64'(re_cnt), 64'(0));
    chk("dr_pulses", 64'(qv_cnt), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
